// File: rtl/river_l1_mem_arbiter.sv
// Two-client (dcache = path 0, icache = path 1) arbiter in front of the River ACE bridge.
// One outstanding transaction; round-robin tie-break; responses routed back by latched path.
module river_l1_mem_arbiter #(
    parameter int ADDR_BITS = 48,
    parameter int LINE_BITS = 256,
    parameter int STRB_BITS = LINE_BITS / 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    // dcache client
    input  logic                 i_c0_req_valid,
    output logic                 o_c0_req_ready,
    input  logic [2:0]           i_c0_req_type,
    input  logic [ADDR_BITS-1:0] i_c0_req_addr,
    input  logic [LINE_BITS-1:0] i_c0_req_wdata,
    input  logic [STRB_BITS-1:0] i_c0_req_wstrb,
    input  logic [2:0]           i_c0_req_size,
    input  logic [2:0]           i_c0_req_prot,
    output logic                 o_c0_resp_valid,
    output logic [LINE_BITS-1:0] o_c0_resp_data,
    output logic                 o_c0_resp_fault,
    // icache client
    input  logic                 i_c1_req_valid,
    output logic                 o_c1_req_ready,
    input  logic [2:0]           i_c1_req_type,
    input  logic [ADDR_BITS-1:0] i_c1_req_addr,
    input  logic [LINE_BITS-1:0] i_c1_req_wdata,
    input  logic [STRB_BITS-1:0] i_c1_req_wstrb,
    input  logic [2:0]           i_c1_req_size,
    input  logic [2:0]           i_c1_req_prot,
    output logic                 o_c1_resp_valid,
    output logic [LINE_BITS-1:0] o_c1_resp_data,
    output logic                 o_c1_resp_fault,
    // bridge side
    output logic                 o_req_valid,
    input  logic                 i_req_ready,
    output logic                 o_req_path,
    output logic [2:0]           o_req_type,
    output logic [ADDR_BITS-1:0] o_req_addr,
    output logic [LINE_BITS-1:0] o_req_wdata,
    output logic [STRB_BITS-1:0] o_req_wstrb,
    output logic [2:0]           o_req_size,
    output logic [2:0]           o_req_prot,
    input  logic                 i_resp_valid,
    input  logic [LINE_BITS-1:0] i_resp_data,
    input  logic                 i_resp_fault
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_next;
    logic   pri;
    logic   grant0, grant1;
    logic   accept, winner;

    // Readies are held low while reset is asserted so nothing is granted mid-reset.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE && !i_rst) begin
            if (i_c0_req_valid && i_c1_req_valid) begin
                grant0 = ~pri;
                grant1 = pri;
            end else begin
                grant0 = i_c0_req_valid;
                grant1 = i_c1_req_valid;
            end
        end
    end

    assign accept = grant0 | grant1;
    assign winner = grant1;

    assign o_c0_req_ready = grant0;
    assign o_c1_req_ready = grant1;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)       state_next = REQ;
            REQ:     if (i_req_ready)  state_next = RESP;
            RESP:    if (i_resp_valid) state_next = IDLE;
            default:                   state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            pri         <= 1'b0;
            o_req_path  <= 1'b0;
            o_req_type  <= '0;
            o_req_addr  <= '0;
            o_req_wdata <= '0;
            o_req_wstrb <= '0;
            o_req_size  <= '0;
            o_req_prot  <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                pri         <= ~winner;
                o_req_path  <= winner;
                o_req_type  <= winner ? i_c1_req_type  : i_c0_req_type;
                o_req_addr  <= winner ? i_c1_req_addr  : i_c0_req_addr;
                o_req_wdata <= winner ? i_c1_req_wdata : i_c0_req_wdata;
                o_req_wstrb <= winner ? i_c1_req_wstrb : i_c0_req_wstrb;
                o_req_size  <= winner ? i_c1_req_size  : i_c0_req_size;
                o_req_prot  <= winner ? i_c1_req_prot  : i_c0_req_prot;
            end
        end
    end

    assign o_req_valid = (state == REQ);

    assign o_c0_resp_valid = (state == RESP) && i_resp_valid && !i_rst && !o_req_path;
    assign o_c1_resp_valid = (state == RESP) && i_resp_valid && !i_rst &&  o_req_path;

    assign o_c0_resp_data  = i_resp_data;
    assign o_c1_resp_data  = i_resp_data;
    assign o_c0_resp_fault = i_resp_fault;
    assign o_c1_resp_fault = i_resp_fault;

endmodule

// File: tb/tb_river_l1_mem_arbiter.sv
// Randomized self-checking bench for river_l1_mem_arbiter against a transaction-level
// model (round-robin pointer, one transaction at a time, response routed to the issuer).
module tb_river_l1_mem_arbiter;
    localparam int AB = 48;
    localparam int LB = 256;
    localparam int SB = LB / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [1:0]    c_valid, c_ready, r_valid, r_fault;
    logic [2:0]    c_type [2];
    logic [AB-1:0] c_addr [2];
    logic [LB-1:0] c_wdata[2];
    logic [SB-1:0] c_wstrb[2];
    logic [2:0]    c_size [2];
    logic [2:0]    c_prot [2];
    logic [LB-1:0] r_data [2];

    logic          o_req_valid, i_req_ready, o_req_path;
    logic [2:0]    o_req_type, o_req_size, o_req_prot;
    logic [AB-1:0] o_req_addr;
    logic [LB-1:0] o_req_wdata;
    logic [SB-1:0] o_req_wstrb;
    logic          i_resp_valid, i_resp_fault;
    logic [LB-1:0] i_resp_data;

    river_l1_mem_arbiter #(.ADDR_BITS(AB), .LINE_BITS(LB), .STRB_BITS(SB)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_c0_req_valid(c_valid[0]), .o_c0_req_ready(c_ready[0]),
        .i_c0_req_type(c_type[0]), .i_c0_req_addr(c_addr[0]), .i_c0_req_wdata(c_wdata[0]),
        .i_c0_req_wstrb(c_wstrb[0]), .i_c0_req_size(c_size[0]), .i_c0_req_prot(c_prot[0]),
        .o_c0_resp_valid(r_valid[0]), .o_c0_resp_data(r_data[0]), .o_c0_resp_fault(r_fault[0]),
        .i_c1_req_valid(c_valid[1]), .o_c1_req_ready(c_ready[1]),
        .i_c1_req_type(c_type[1]), .i_c1_req_addr(c_addr[1]), .i_c1_req_wdata(c_wdata[1]),
        .i_c1_req_wstrb(c_wstrb[1]), .i_c1_req_size(c_size[1]), .i_c1_req_prot(c_prot[1]),
        .o_c1_resp_valid(r_valid[1]), .o_c1_resp_data(r_data[1]), .o_c1_resp_fault(r_fault[1]),
        .o_req_valid(o_req_valid), .i_req_ready(i_req_ready), .o_req_path(o_req_path),
        .o_req_type(o_req_type), .o_req_addr(o_req_addr), .o_req_wdata(o_req_wdata),
        .o_req_wstrb(o_req_wstrb), .o_req_size(o_req_size), .o_req_prot(o_req_prot),
        .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data), .i_resp_fault(i_resp_fault)
    );

    int checks = 0;
    int errors = 0;
    bit m_pri;

    // observations recorded by the transaction driver
    int            obs_winner, obs_req_cycles, obs_busy_ready, obs_r0, obs_r1, obs_unstable;
    bit            obs_timeout, obs_both_ready, obs_lat, first;
    logic          obs_path, obs_rfault;
    logic [2:0]    obs_type, obs_size, obs_prot;
    logic [AB-1:0] obs_addr;
    logic [LB-1:0] obs_wdata, obs_rdata;
    logic [SB-1:0] obs_wstrb;

    function automatic logic [LB-1:0] rnd_line();
        logic [LB-1:0] v;
        for (int i = 0; i < LB / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic rand_client(input int c);
        c_type[c]  = 3'($urandom);
        c_addr[c]  = {16'($urandom), 32'($urandom)};
        c_wdata[c] = rnd_line();
        c_wstrb[c] = SB'($urandom);
        c_size[c]  = 3'($urandom);
        c_prot[c]  = 3'($urandom);
    endtask

    function automatic int model_winner();
        if (c_valid[0] && c_valid[1]) return int'(m_pri);
        return c_valid[1] ? 1 : 0;
    endfunction

    task automatic sample_busy();
        obs_req_cycles += int'(o_req_valid);
        obs_busy_ready += int'(c_ready[0]) + int'(c_ready[1]);
        obs_r0 += int'(r_valid[0]);
        obs_r1 += int'(r_valid[1]);
        if (first) begin
            first = 0;
            obs_lat = o_req_valid; obs_path = o_req_path; obs_type = o_req_type;
            obs_addr = o_req_addr; obs_wdata = o_req_wdata; obs_wstrb = o_req_wstrb;
            obs_size = o_req_size; obs_prot = o_req_prot;
        end else if (o_req_addr !== obs_addr || o_req_wdata !== obs_wdata || o_req_wstrb !== obs_wstrb ||
                     o_req_type !== obs_type || o_req_path !== obs_path) begin
            obs_unstable++;
        end
    endtask

    // Drives one complete transaction from IDLE; caller sets client valids/fields beforehand.
    task automatic run_txn(input int req_dly, input int resp_dly, input bit spur,
                           input logic [LB-1:0] rdata, input logic rfault);
        obs_winner = -1; obs_timeout = 0; obs_both_ready = 0; obs_req_cycles = 0;
        obs_busy_ready = 0; obs_r0 = 0; obs_r1 = 0; obs_unstable = 0; first = 1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (c_ready[0] || c_ready[1]) begin
                obs_winner = c_ready[1] ? 1 : 0;
                obs_both_ready = c_ready[0] & c_ready[1];
                break;
            end
            @(posedge clk); #1;
        end
        if (obs_winner < 0) begin
            obs_timeout = 1;
            return;
        end
        @(posedge clk); #1;
        c_valid[obs_winner] = 1'b0;
        for (int k = 0; k <= req_dly; k++) begin
            i_req_ready  = (k == req_dly);
            i_resp_valid = spur && (k != req_dly);
            i_resp_data  = rnd_line();
            i_resp_fault = 1'($urandom);
            @(negedge clk); sample_busy();
            @(posedge clk); #1;
        end
        i_req_ready = 1'b0; i_resp_valid = 1'b0;
        for (int k = 0; k < resp_dly; k++) begin
            @(negedge clk); sample_busy();
            @(posedge clk); #1;
        end
        i_resp_valid = 1'b1; i_resp_data = rdata; i_resp_fault = rfault;
        @(negedge clk); sample_busy();
        obs_rdata = r_data[obs_winner]; obs_rfault = r_fault[obs_winner];
        @(posedge clk); #1;
        i_resp_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_pri = 1'b0;
    endtask

    task automatic test_reset();
        rand_client(0); rand_client(1);
        c_valid = 2'b01; rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (c_ready !== 2'b00) begin errors++; $display("FAIL rst_ready got %b want 00", c_ready); end
        checks++; if (o_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got %b want 0", o_req_valid); end
        @(posedge clk); #1;
        c_valid = 2'b00; rst = 1'b0; m_pri = 1'b0;
        @(negedge clk);
        checks++; if (o_req_addr !== '0 || o_req_wdata !== '0 || o_req_wstrb !== '0 || o_req_type !== '0 || o_req_path !== 1'b0)
            begin errors++; $display("FAIL rst_fields got addr %h path %b want 0", o_req_addr, o_req_path); end
        checks++; if ({r_valid, c_ready, o_req_valid} !== 5'b0)
            begin errors++; $display("FAIL rst_outputs got %b want 00000", {r_valid, c_ready, o_req_valid}); end
        @(posedge clk); #1;
    endtask

    task automatic test_single_read();
        logic [LB-1:0] a5;
        a5 = {(LB/8){8'hA5}};
        rand_client(0);
        c_type[0] = 3'b000; c_addr[0] = AB'(48'h0000_8000_0000);
        c_valid = 2'b01;
        run_txn(0, 2, 0, a5, 1'b0);
        m_pri = 1'b1;
        checks++; if (obs_winner !== 0) begin errors++; $display("FAIL rd_winner got %0d want 0", obs_winner); end
        checks++; if (obs_lat !== 1'b1) begin errors++; $display("FAIL rd_latency req_valid got %b want 1", obs_lat); end
        checks++; if (obs_path !== 1'b0 || obs_addr !== AB'(48'h0000_8000_0000))
            begin errors++; $display("FAIL rd_fields got path %b addr %h want 0 80000000", obs_path, obs_addr); end
        checks++; if (obs_r0 !== 1 || obs_r1 !== 0)
            begin errors++; $display("FAIL rd_resp got r0 %0d r1 %0d want 1 0", obs_r0, obs_r1); end
        checks++; if (obs_rdata !== a5) begin errors++; $display("FAIL rd_data got %h want %h", obs_rdata, a5); end
    endtask

    task automatic test_round_robin();
        int exp_w;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            if (!c_valid[0]) rand_client(0);
            if (!c_valid[1]) rand_client(1);
            c_valid = 2'b11;
            exp_w = model_winner();
            run_txn(0, 0, 0, rnd_line(), 1'b0);
            m_pri = ~1'(exp_w);
            checks++; if (obs_winner !== exp_w || obs_winner !== (i % 2))
                begin errors++; $display("FAIL rr_winner[%0d] got %0d want %0d", i, obs_winner, exp_w); end
            checks++; if (obs_both_ready !== 1'b0) begin errors++; $display("FAIL rr_both_ready[%0d] got 1 want 0", i); end
        end
        c_valid = 2'b00;
    endtask

    task automatic test_stall();
        rand_client(1);
        c_valid = 2'b10;
        run_txn(5, 1, 0, rnd_line(), 1'b0);
        m_pri = 1'b0;
        checks++; if (obs_req_cycles !== 6) begin errors++; $display("FAIL stall_req_cycles got %0d want 6", obs_req_cycles); end
        checks++; if (obs_unstable !== 0) begin errors++; $display("FAIL stall_stable got %0d changes want 0", obs_unstable); end
        checks++; if (obs_busy_ready !== 0) begin errors++; $display("FAIL stall_ready got %0d want 0", obs_busy_ready); end
        checks++; if (obs_addr !== c_addr[1] || obs_wdata !== c_wdata[1] || obs_wstrb !== c_wstrb[1])
            begin errors++; $display("FAIL stall_fields got addr %h want %h", obs_addr, c_addr[1]); end
    endtask

    task automatic test_spurious_resp();
        logic [LB-1:0] d;
        d = rnd_line();
        rand_client(0);
        c_valid = 2'b01;
        run_txn(3, 1, 1, d, 1'b0);
        m_pri = 1'b1;
        checks++; if (obs_r0 !== 1 || obs_r1 !== 0)
            begin errors++; $display("FAIL spur_resp got r0 %0d r1 %0d want 1 0", obs_r0, obs_r1); end
        checks++; if (obs_rdata !== d) begin errors++; $display("FAIL spur_data got %h want %h", obs_rdata, d); end
    endtask

    task automatic test_fault();
        rand_client(1);
        c_valid = 2'b10;
        run_txn(0, 0, 0, rnd_line(), 1'b1);
        m_pri = 1'b0;
        checks++; if (obs_r1 !== 1 || obs_r0 !== 0)
            begin errors++; $display("FAIL fault_resp got r0 %0d r1 %0d want 0 1", obs_r0, obs_r1); end
        checks++; if (obs_rfault !== 1'b1) begin errors++; $display("FAIL fault_flag got %b want 1", obs_rfault); end
    endtask

    task automatic test_reset_in_resp();
        logic [LB-1:0] d;
        rand_client(0);
        c_valid = 2'b01;
        @(negedge clk);
        checks++; if (c_ready !== 2'b01) begin errors++; $display("FAIL rir_accept got %b want 01", c_ready); end
        @(posedge clk); #1;
        c_valid = 2'b00; i_req_ready = 1'b1;
        @(posedge clk); #1;
        i_req_ready = 1'b0;
        rand_client(0);
        c_valid = 2'b01; rst = 1'b1; i_resp_valid = 1'b1; i_resp_data = rnd_line();
        @(negedge clk);
        checks++; if (r_valid !== 2'b00 || c_ready !== 2'b00)
            begin errors++; $display("FAIL rir_drop got resp %b ready %b want 00 00", r_valid, c_ready); end
        @(posedge clk); #1;
        rst = 1'b0; i_resp_valid = 1'b0; m_pri = 1'b0;
        @(negedge clk);
        checks++; if (o_req_valid !== 1'b0 || o_req_addr !== '0 || c_ready !== 2'b01)
            begin errors++; $display("FAIL rir_idle got req_valid %b addr %h ready %b want 0 0 01", o_req_valid, o_req_addr, c_ready); end
        @(posedge clk); #1;
        c_valid = 2'b00; i_req_ready = 1'b1;
        @(negedge clk);
        checks++; if (o_req_valid !== 1'b1 || o_req_addr !== c_addr[0])
            begin errors++; $display("FAIL rir_newreq got %b %h want 1 %h", o_req_valid, o_req_addr, c_addr[0]); end
        @(posedge clk); #1;
        d = rnd_line();
        i_req_ready = 1'b0; i_resp_valid = 1'b1; i_resp_data = d; i_resp_fault = 1'b0;
        @(negedge clk);
        checks++; if (r_valid !== 2'b01 || r_data[0] !== d)
            begin errors++; $display("FAIL rir_resp got valid %b data %h want 01 %h", r_valid, r_data[0], d); end
        @(posedge clk); #1;
        i_resp_valid = 1'b0; m_pri = 1'b1;
    endtask

    task automatic test_random();
        int exp_w, rq, rs;
        logic [LB-1:0] d;
        logic f;
        for (int i = 0; i < 40; i++) begin
            for (int c = 0; c < 2; c++)
                if (!c_valid[c] && $urandom_range(0, 1) == 1) begin rand_client(c); c_valid[c] = 1'b1; end
            if (c_valid == 2'b00) begin
                exp_w = $urandom_range(0, 1);
                rand_client(exp_w); c_valid[exp_w] = 1'b1;
            end
            exp_w = model_winner();
            rq = $urandom_range(0, 3); rs = $urandom_range(0, 3);
            d = rnd_line(); f = 1'($urandom);
            run_txn(rq, rs, 1'($urandom), d, f);
            m_pri = ~1'(exp_w);
            checks++; if (obs_timeout || obs_winner !== exp_w)
                begin errors++; $display("FAIL rnd_winner[%0d] got %0d want %0d", i, obs_winner, exp_w); end
            if (obs_timeout) continue;
            checks++; if (obs_lat !== 1'b1 || obs_req_cycles !== rq + 1 || obs_unstable !== 0 || obs_busy_ready !== 0)
                begin errors++; $display("FAIL rnd_req[%0d] got lat %b cyc %0d unst %0d rdy %0d want 1 %0d 0 0",
                                         i, obs_lat, obs_req_cycles, obs_unstable, obs_busy_ready, rq + 1); end
            checks++; if (obs_path !== 1'(exp_w) || obs_type !== c_type[exp_w] || obs_addr !== c_addr[exp_w] ||
                          obs_wdata !== c_wdata[exp_w] || obs_wstrb !== c_wstrb[exp_w] ||
                          obs_size !== c_size[exp_w] || obs_prot !== c_prot[exp_w])
                begin errors++; $display("FAIL rnd_fields[%0d] got path %b addr %h want %0d %h", i, obs_path, obs_addr, exp_w, c_addr[exp_w]); end
            checks++; if (obs_r0 !== int'(exp_w == 0) || obs_r1 !== int'(exp_w == 1) || obs_rdata !== d || obs_rfault !== f)
                begin errors++; $display("FAIL rnd_resp[%0d] got r0 %0d r1 %0d fault %b want path %0d fault %b", i, obs_r0, obs_r1, obs_rfault, exp_w, f); end
        end
        c_valid = 2'b00;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit expired");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; c_valid = 2'b00; i_req_ready = 1'b0;
        i_resp_valid = 1'b0; i_resp_data = '0; i_resp_fault = 1'b0;
        m_pri = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_single_read();
        test_round_robin();
        test_stall();
        test_spurious_resp();
        test_fault();
        test_reset_in_resp();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
